// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 keyboard controller.
//   ps2_state_e : prefix FSM state encoding
//   SC_*        : scan-code-set-2 prefix and shift constants
//   KEY_*       : Hack key codes 128..152 for non-printing keys
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } ps2_state_e;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  // Bytes that follow E1 in the pause make/break sequence.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam logic [15:0] KEY_ENTER = 16'd128;
  localparam logic [15:0] KEY_BKSP  = 16'd129;
  localparam logic [15:0] KEY_LEFT  = 16'd130;
  localparam logic [15:0] KEY_UP    = 16'd131;
  localparam logic [15:0] KEY_RIGHT = 16'd132;
  localparam logic [15:0] KEY_DOWN  = 16'd133;
  localparam logic [15:0] KEY_HOME  = 16'd134;
  localparam logic [15:0] KEY_END   = 16'd135;
  localparam logic [15:0] KEY_PGUP  = 16'd136;
  localparam logic [15:0] KEY_PGDN  = 16'd137;
  localparam logic [15:0] KEY_INS   = 16'd138;
  localparam logic [15:0] KEY_DEL   = 16'd139;
  localparam logic [15:0] KEY_ESC   = 16'd140;
  localparam logic [15:0] KEY_F1    = 16'd141;

endpackage

// File: rtl/ps2_keymap.sv
// ps2_keymap -- combinational scan-code-set-2 to Hack key-code translation.
//   ext   : byte was preceded by E0
//   code  : scan code
//   shift : either shift key held
//   key   : Hack key code, 0 when the code is unmapped
module ps2_keymap
  import ps2_pkg::*;
(
  input  logic        ext,
  input  logic [7:0]  code,
  input  logic        shift,
  output logic [15:0] key
);

  logic       letter;
  logic [4:0] idx;
  logic       sym;
  logic [7:0] lo;
  logic [7:0] hi;

  always_comb begin
    key    = '0;
    letter = 1'b0;
    idx    = '0;
    sym    = 1'b0;
    lo     = '0;
    hi     = '0;
    if (ext) begin
      case (code)
        8'h6B:   key = KEY_LEFT;
        8'h75:   key = KEY_UP;
        8'h74:   key = KEY_RIGHT;
        8'h72:   key = KEY_DOWN;
        8'h6C:   key = KEY_HOME;
        8'h69:   key = KEY_END;
        8'h7D:   key = KEY_PGUP;
        8'h7A:   key = KEY_PGDN;
        8'h70:   key = KEY_INS;
        8'h71:   key = KEY_DEL;
        default: key = '0;
      endcase
    end else begin
      case (code)
        // letters, index from 'a'
        8'h1C: begin letter = 1'b1; idx = 5'd0;  end
        8'h32: begin letter = 1'b1; idx = 5'd1;  end
        8'h21: begin letter = 1'b1; idx = 5'd2;  end
        8'h23: begin letter = 1'b1; idx = 5'd3;  end
        8'h24: begin letter = 1'b1; idx = 5'd4;  end
        8'h2B: begin letter = 1'b1; idx = 5'd5;  end
        8'h34: begin letter = 1'b1; idx = 5'd6;  end
        8'h33: begin letter = 1'b1; idx = 5'd7;  end
        8'h43: begin letter = 1'b1; idx = 5'd8;  end
        8'h3B: begin letter = 1'b1; idx = 5'd9;  end
        8'h42: begin letter = 1'b1; idx = 5'd10; end
        8'h4B: begin letter = 1'b1; idx = 5'd11; end
        8'h3A: begin letter = 1'b1; idx = 5'd12; end
        8'h31: begin letter = 1'b1; idx = 5'd13; end
        8'h44: begin letter = 1'b1; idx = 5'd14; end
        8'h4D: begin letter = 1'b1; idx = 5'd15; end
        8'h15: begin letter = 1'b1; idx = 5'd16; end
        8'h2D: begin letter = 1'b1; idx = 5'd17; end
        8'h1B: begin letter = 1'b1; idx = 5'd18; end
        8'h2C: begin letter = 1'b1; idx = 5'd19; end
        8'h3C: begin letter = 1'b1; idx = 5'd20; end
        8'h2A: begin letter = 1'b1; idx = 5'd21; end
        8'h1D: begin letter = 1'b1; idx = 5'd22; end
        8'h22: begin letter = 1'b1; idx = 5'd23; end
        8'h35: begin letter = 1'b1; idx = 5'd24; end
        8'h1A: begin letter = 1'b1; idx = 5'd25; end
        // digits and punctuation: unshifted / shifted ASCII
        8'h16: begin sym = 1'b1; lo = 8'd49; hi = 8'd33;  end
        8'h1E: begin sym = 1'b1; lo = 8'd50; hi = 8'd64;  end
        8'h26: begin sym = 1'b1; lo = 8'd51; hi = 8'd35;  end
        8'h25: begin sym = 1'b1; lo = 8'd52; hi = 8'd36;  end
        8'h2E: begin sym = 1'b1; lo = 8'd53; hi = 8'd37;  end
        8'h36: begin sym = 1'b1; lo = 8'd54; hi = 8'd94;  end
        8'h3D: begin sym = 1'b1; lo = 8'd55; hi = 8'd38;  end
        8'h3E: begin sym = 1'b1; lo = 8'd56; hi = 8'd42;  end
        8'h46: begin sym = 1'b1; lo = 8'd57; hi = 8'd40;  end
        8'h45: begin sym = 1'b1; lo = 8'd48; hi = 8'd41;  end
        8'h0E: begin sym = 1'b1; lo = 8'd96; hi = 8'd126; end
        8'h4E: begin sym = 1'b1; lo = 8'd45; hi = 8'd95;  end
        8'h55: begin sym = 1'b1; lo = 8'd61; hi = 8'd43;  end
        8'h54: begin sym = 1'b1; lo = 8'd91; hi = 8'd123; end
        8'h5B: begin sym = 1'b1; lo = 8'd93; hi = 8'd125; end
        8'h5D: begin sym = 1'b1; lo = 8'd92; hi = 8'd124; end
        8'h4C: begin sym = 1'b1; lo = 8'd59; hi = 8'd58;  end
        8'h52: begin sym = 1'b1; lo = 8'd39; hi = 8'd34;  end
        8'h41: begin sym = 1'b1; lo = 8'd44; hi = 8'd60;  end
        8'h49: begin sym = 1'b1; lo = 8'd46; hi = 8'd62;  end
        8'h4A: begin sym = 1'b1; lo = 8'd47; hi = 8'd63;  end
        8'h29: begin sym = 1'b1; lo = 8'd32; hi = 8'd32;  end
        // control and function keys
        8'h5A: key = KEY_ENTER;
        8'h66: key = KEY_BKSP;
        8'h76: key = KEY_ESC;
        8'h05: key = KEY_F1;
        8'h06: key = KEY_F1 + 16'd1;
        8'h04: key = KEY_F1 + 16'd2;
        8'h0C: key = KEY_F1 + 16'd3;
        8'h03: key = KEY_F1 + 16'd4;
        8'h0B: key = KEY_F1 + 16'd5;
        8'h83: key = KEY_F1 + 16'd6;
        8'h0A: key = KEY_F1 + 16'd7;
        8'h01: key = KEY_F1 + 16'd8;
        8'h09: key = KEY_F1 + 16'd9;
        8'h78: key = KEY_F1 + 16'd10;
        8'h07: key = KEY_F1 + 16'd11;
        default: key = '0;
      endcase
      if (letter) begin
        key = {8'd0, (shift ? 8'd65 : 8'd97) + {3'd0, idx}};
      end else if (sym) begin
        key = {8'd0, (shift ? hi : lo)};
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_ctrl.sv
// ps2_keyboard_ctrl -- turns the PS/2 decoder byte stream into the Hack
// keyboard register value.
//   i_clock      : system clock
//   reset_n      : asynchronous active-low reset
//   i_scan_ready : decoder ready flag, asynchronous to i_clock
//   i_scan_code  : decoder byte, stable while i_scan_ready is high
//   o_key        : Hack code of the held key, 0 when none
//   o_key_event  : one-cycle pulse when o_key changes
//   o_shift      : either shift key held
// Build option: define PS2_KBD_TIMEOUT_EN to abandon a pending prefix after
// TIMEOUT_CYCLES clocks without a byte.
module ps2_keyboard_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        i_clock,
  input  logic        reset_n,
  input  logic        i_scan_ready,
  input  logic [7:0]  i_scan_code,
  output logic [15:0] o_key,
  output logic        o_key_event,
  output logic        o_shift
);

  logic       rdy_sync_p0;
  logic       rdy_sync_p1;
  logic       rdy_prev_p2;
  logic       vld_p3;
  logic [7:0] code_p3;
  logic       rise_p2;

  ps2_state_e state_q, state_nxt;
  logic [2:0]  skip_q, skip_nxt;
  logic [8:0]  held_q, held_nxt;
  logic        shl_q, shl_nxt;
  logic        shr_q, shr_nxt;
  logic [15:0] key_nxt;
  logic        is_make;
  logic        is_brk;
  logic        ext;
  logic        is_lshift;
  logic        is_rshift;
  logic [15:0] map_key;

  // Stages p0..p2: synchronizer and previous-value flop. Reset high so a
  // ready flag already high at reset exit is not seen as a new byte.
  always_ff @(posedge i_clock or negedge reset_n) begin
    if (!reset_n) begin
      rdy_sync_p0 <= 1'b1;
      rdy_sync_p1 <= 1'b1;
      rdy_prev_p2 <= 1'b1;
      vld_p3      <= 1'b0;
    end else begin
      rdy_sync_p0 <= i_scan_ready;
      rdy_sync_p1 <= rdy_sync_p0;
      rdy_prev_p2 <= rdy_sync_p1;
      vld_p3      <= rise_p2;
    end
  end

  assign rise_p2 = rdy_sync_p1 & ~rdy_prev_p2;

  // Stage p3: byte captured with the strobe
  always_ff @(posedge i_clock) begin
    if (rise_p2) begin
      code_p3 <= i_scan_code;
    end
  end

  assign is_lshift = (code_p3 == SC_LSHIFT);
  assign is_rshift = (code_p3 == SC_RSHIFT);

  ps2_keymap u_keymap (
    .ext   (ext),
    .code  (code_p3),
    .shift (o_shift),
    .key   (map_key)
  );

`ifdef PS2_KBD_TIMEOUT_EN
  localparam logic [31:0] TMO_LIM = 32'(TIMEOUT_CYCLES);
  logic [31:0] tmo_q, tmo_nxt;
  logic        tmo_hit;

  assign tmo_hit = !vld_p3 && (state_q != ST_IDLE) && (tmo_q == TMO_LIM);

  always_comb begin
    tmo_nxt = '0;
    if (!vld_p3 && state_q != ST_IDLE && !tmo_hit) begin
      tmo_nxt = tmo_q + 32'd1;
    end
  end

  always_ff @(posedge i_clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_nxt;
    end
  end
`else
  // Parameter is kept in the port list so both builds share one interface.
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_nxt = state_q;
    skip_nxt  = skip_q;
    held_nxt  = held_q;
    shl_nxt   = shl_q;
    shr_nxt   = shr_q;
    key_nxt   = o_key;
    is_make   = 1'b0;
    is_brk    = 1'b0;
    ext       = 1'b0;

    if (vld_p3) begin
      case (state_q)
        ST_IDLE: begin
          if (code_p3 == SC_EXT) begin
            state_nxt = ST_EXT;
          end else if (code_p3 == SC_BRK) begin
            state_nxt = ST_BRK;
          end else if (code_p3 == SC_PAUSE) begin
            state_nxt = ST_SKIP;
            skip_nxt  = PAUSE_SKIP;
          end else begin
            is_make = 1'b1;
          end
        end
        ST_EXT: begin
          if (code_p3 == SC_BRK) begin
            state_nxt = ST_EXT_BRK;
          end else begin
            is_make   = 1'b1;
            ext       = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          is_brk    = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_EXT_BRK: begin
          is_brk    = 1'b1;
          ext       = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_SKIP: begin
          skip_nxt = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    // Extended E0 12 / E0 59 are fake shifts and go through the keymap
    // (where they are unmapped) rather than touching the shift state.
    if (is_make) begin
      if (!ext && is_lshift) begin
        shl_nxt = 1'b1;
      end else if (!ext && is_rshift) begin
        shr_nxt = 1'b1;
      end else if (map_key != '0) begin
        held_nxt = {ext, code_p3};
        key_nxt  = map_key;
      end
    end

    if (is_brk) begin
      if (!ext && is_lshift) begin
        shl_nxt = 1'b0;
      end else if (!ext && is_rshift) begin
        shr_nxt = 1'b0;
      end else if ({ext, code_p3} == held_q) begin
        held_nxt = '0;
        key_nxt  = '0;
      end
    end

`ifdef PS2_KBD_TIMEOUT_EN
    if (tmo_hit) begin
      state_nxt = ST_IDLE;
      skip_nxt  = '0;
    end
`endif
  end

  // Stage p4: registered outputs
  always_ff @(posedge i_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      skip_q      <= '0;
      held_q      <= '0;
      shl_q       <= 1'b0;
      shr_q       <= 1'b0;
      o_key       <= '0;
      o_key_event <= 1'b0;
      o_shift     <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      skip_q      <= skip_nxt;
      held_q      <= held_nxt;
      shl_q       <= shl_nxt;
      shr_q       <= shr_nxt;
      o_key       <= key_nxt;
      o_key_event <= (key_nxt != o_key);
      o_shift     <= shl_nxt | shr_nxt;
    end
  end

endmodule
